// File: rtl/fifo_packetizer.sv
// -----------------------------------------------------------------------------
// fifo_packetizer
//
// Drains an upstream sample FIFO in fixed-length bursts and emits framed
// packets on a valid/ready stream. Each packet is a header word carrying the
// packet sequence number, BurstLen payload words taken from the FIFO in order,
// and a trailer word holding the modular sum of the payload (carries dropped).
//
// FIFO words arrive one cycle after the read strobe. They land in a 2-entry
// skid buffer, which decouples FIFO reads from downstream back-pressure.
//
// Ports
//   clk         clock, all logic on the rising edge
//   rst         synchronous active-low reset
//   enable      permits a new packet to start (looked at only while idle)
//   fifo_level  FIFO occupancy in words
//   fifo_empty  FIFO empty flag
//   fifo_rd     FIFO read strobe, one word per asserted cycle
//   fifo_data   FIFO read data, valid the cycle after fifo_rd
//   out_data    stream word
//   out_valid   stream word valid
//   out_ready   downstream accepts the word
//   out_last    marks the trailer word
//   busy        high whenever a packet is in progress
//   pkt_count   packets completed since reset, wraps at 16 bits
// -----------------------------------------------------------------------------
module fifo_packetizer #(
    parameter int DataWidth  = 16,
    parameter int BurstLen   = 64,
    parameter int LevelWidth = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [LevelWidth-1:0] fifo_level,
    input  logic                  fifo_empty,
    output logic                  fifo_rd,
    input  logic [DataWidth-1:0]  fifo_data,
    output logic [DataWidth-1:0]  out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic [15:0]           pkt_count
);

    localparam int CntWidth = $clog2(BurstLen + 1);
    localparam logic [CntWidth-1:0]   BurstLenC = CntWidth'(BurstLen);
    localparam logic [CntWidth-1:0]   LastIdx   = CntWidth'(BurstLen - 1);
    localparam logic [LevelWidth-1:0] LevelC    = LevelWidth'(BurstLen);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEADER,
        ST_PAYLOAD,
        ST_TRAILER
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [15:0]           r_seq;
    logic [DataWidth-1:0]  r_checksum;
    logic [CntWidth-1:0]   r_req_cnt;
    logic [CntWidth-1:0]   r_sent_cnt;
    logic [1:0]            r_buf_cnt;
    logic                  r_rd_q;
    logic [DataWidth-1:0]  r_buf0;   // head of the skid buffer
    logic [DataWidth-1:0]  r_buf1;

    logic                  w_pop;
    logic                  w_push;
    logic                  w_rd_state;
    logic                  w_wr_slot0;
    logic                  w_trailer_done;
    logic [2:0]            w_occ;
    logic [DataWidth-1:0]  w_seq_ext;

    assign w_seq_ext      = DataWidth'(r_seq);
    assign w_pop          = (r_state == ST_PAYLOAD) && (r_buf_cnt != 2'd0) && out_ready;
    assign w_push         = r_rd_q;
    assign w_rd_state     = (r_state == ST_HEADER) || (r_state == ST_PAYLOAD);
    assign w_trailer_done = (r_state == ST_TRAILER) && out_ready;

    // Buffer occupancy once the word already in flight from the FIFO has
    // landed and this cycle's pop has left; a new read is only safe below 2.
    assign w_occ   = {1'b0, r_buf_cnt} + {2'b00, r_rd_q} - {2'b00, w_pop};
    assign fifo_rd = w_rd_state && !fifo_empty && (r_req_cnt < BurstLenC) && (w_occ < 3'd2);

    // The incoming word goes to the head slot when the buffer is, or is about
    // to become, empty; otherwise it queues behind the head.
    assign w_wr_slot0 = (r_buf_cnt == 2'd0) || ((r_buf_cnt == 2'd1) && w_pop);

    assign busy      = (r_state != ST_IDLE);
    assign pkt_count = r_seq;

    // NOTE: every variable assigned here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        out_data     = '0;
        out_valid    = 1'b0;
        out_last     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable && (fifo_level >= LevelC)) begin
                    w_next_state = ST_HEADER;
                end
            end
            ST_HEADER: begin
                out_data  = w_seq_ext;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                out_data  = r_buf0;
                out_valid = (r_buf_cnt != 2'd0);
                if (w_pop && (r_sent_cnt == LastIdx)) begin
                    w_next_state = ST_TRAILER;
                end
            end
            ST_TRAILER: begin
                out_data  = r_checksum;
                out_valid = 1'b1;
                out_last  = 1'b1;
                if (out_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_seq      <= '0;
            r_checksum <= '0;
            r_req_cnt  <= '0;
            r_sent_cnt <= '0;
            r_buf_cnt  <= '0;
            r_rd_q     <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_rd_q  <= fifo_rd;

            case ({w_push, w_pop})
                2'b10:   r_buf_cnt <= r_buf_cnt + 2'd1;
                2'b01:   r_buf_cnt <= r_buf_cnt - 2'd1;
                default: r_buf_cnt <= r_buf_cnt;
            endcase

            if (fifo_rd) begin
                r_req_cnt <= r_req_cnt + 1'b1;
            end

            if (w_pop) begin
                r_checksum <= r_checksum + r_buf0;
                r_sent_cnt <= r_sent_cnt + 1'b1;
            end

            if (w_trailer_done) begin
                r_seq      <= r_seq + 16'd1;
                r_checksum <= '0;
                r_req_cnt  <= '0;
                r_sent_cnt <= '0;
            end
        end
    end

    // NOTE: the buffer storage has no reset; r_buf_cnt alone decides which
    // entries are meaningful, so stale contents are never observed as valid.
    always_ff @(posedge clk) begin
        if (w_pop) begin
            r_buf0 <= r_buf1;
        end
        if (w_push) begin
            if (w_wr_slot0) begin
                r_buf0 <= fifo_data;
            end else begin
                r_buf1 <= fifo_data;
            end
        end
    end

endmodule

// File: tb/tb_fifo_packetizer.sv
// -----------------------------------------------------------------------------
// tb_fifo_packetizer
//
// Drives fifo_packetizer (BurstLen = 4) from a queue-based FIFO model and
// scores the output stream against a queue of expected beats built directly
// from the packet framing rules: header = sequence number, payload in FIFO
// order, trailer = payload sum mod 2^16 with out_last set.
// -----------------------------------------------------------------------------
module tb_fifo_packetizer;

    localparam int DW = 16;
    localparam int BL = 4;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [LW-1:0] fifo_level;
    logic          fifo_empty;
    logic          fifo_rd;
    logic [DW-1:0] fifo_data;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          busy;
    logic [15:0]   pkt_count;

    always #5 clk = ~clk;

    fifo_packetizer #(
        .DataWidth (DW),
        .BurstLen  (BL),
        .LevelWidth(LW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .fifo_level(fifo_level),
        .fifo_empty(fifo_empty),
        .fifo_rd   (fifo_rd),
        .fifo_data (fifo_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .pkt_count (pkt_count)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t         exp_q[$];
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] pkt_w[BL];

    int n_tests = 0;
    int n_fail  = 0;
    int n_rd    = 0;
    int n_beats = 0;
    int model_seq = 0;
    int idle_since_trailer = 0;
    int last_gap = -1;
    bit prev_busy = 1'b0;
    bit rand_ready = 1'b0;
    bit glitch_empty = 1'b0;
    bit force_empty = 1'b0;
    bit hold_pending = 1'b0;
    logic [DW-1:0] hold_data;
    logic          hold_last;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
        end
    endtask

    task automatic update_flags();
        fifo_level = LW'(fifo_q.size());
        fifo_empty = (fifo_q.size() == 0) || force_empty;
    endtask

    task automatic fill_random();
        for (int i = 0; i < BL; i++) pkt_w[i] = DW'($urandom);
    endtask

    task automatic fill_const(input logic [DW-1:0] v);
        for (int i = 0; i < BL; i++) pkt_w[i] = v;
    endtask

    // Expected framing of the packet currently in pkt_w.
    task automatic expect_packet();
        beat_t b;
        int    sum;
        sum    = 0;
        b.data = DW'(model_seq);
        b.last = 1'b0;
        exp_q.push_back(b);
        for (int i = 0; i < BL; i++) begin
            b.data = pkt_w[i];
            exp_q.push_back(b);
            sum += int'(pkt_w[i]);
        end
        b.data = DW'(sum);
        b.last = 1'b1;
        exp_q.push_back(b);
        model_seq = (model_seq + 1) & 16'hFFFF;
    endtask

    task automatic load_packet();
        expect_packet();
        for (int i = 0; i < BL; i++) fifo_q.push_back(pkt_w[i]);
        update_flags();
    endtask

    // One clock: sample and score at the falling edge, then update the FIFO
    // model and inputs just after the rising edge.
    task automatic tick();
        bit    rd_seen;
        beat_t b;
        @(negedge clk);
        rd_seen = fifo_rd;
        if (rst) begin
            if (fifo_rd) begin
                n_rd++;
                check("rd_while_empty", fifo_empty, 1'b0);
            end
            if (hold_pending) begin
                check("hold_valid", out_valid, 1'b1);
                check("hold_data", out_data, hold_data);
                check("hold_last", out_last, hold_last);
            end
            if (busy && !prev_busy) last_gap = idle_since_trailer;
            if (!busy) idle_since_trailer++;
            prev_busy = busy;
            if (out_valid && out_ready) begin
                n_beats++;
                if (exp_q.size() == 0) begin
                    check("beats_pending", exp_q.size(), 1);
                end else begin
                    b = exp_q.pop_front();
                    check("data", out_data, b.data);
                    check("last", out_last, b.last);
                end
                if (out_last) idle_since_trailer = 0;
            end
            hold_pending = out_valid && !out_ready;
            hold_data    = out_data;
            hold_last    = out_last;
        end else begin
            hold_pending = 1'b0;
            prev_busy    = 1'b0;
        end
        @(posedge clk);
        #1;
        if (rd_seen) begin
            if (fifo_q.size() == 0) check("fifo_underflow", fifo_q.size(), 1);
            else fifo_data = fifo_q.pop_front();
        end
        if (glitch_empty) force_empty = ($urandom_range(3) == 0);
        update_flags();
        out_ready = rand_ready ? 1'($urandom_range(1)) : 1'b1;
    endtask

    task automatic run_until_drained(input int budget);
        int cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < budget) begin
            tick();
            cyc++;
        end
        check("drained", exp_q.size(), 0);
    endtask

    task automatic wait_beats(input int n);
        int b0;
        int g;
        b0 = n_beats;
        g  = 0;
        while ((n_beats - b0) < n && g < 100) begin
            tick();
            g++;
        end
        check("beats_reached", ((n_beats - b0) >= n), 1'b1);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_fifo_rd"}, fifo_rd, 1'b0);
        check({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_out_last"}, out_last, 1'b0);
        check({tag, "_out_data"}, out_data, 16'h0000);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_pkt_count"}, pkt_count, 16'h0000);
    endtask

    initial begin
        int rd0;

        rst       = 1'b0;
        enable    = 1'b0;
        out_ready = 1'b1;
        fifo_data = '0;
        update_flags();
        repeat (2) @(posedge clk);
        #1;
        check_reset("por");
        rst    = 1'b1;
        enable = 1'b1;

        // Directed packet 1,2,3,4.
        for (int i = 0; i < BL; i++) pkt_w[i] = DW'(i + 1);
        load_packet();
        rd0 = n_rd;
        run_until_drained(100);
        check("directed_rd_pulses", n_rd - rd0, BL);
        check("directed_pkt_count", pkt_count, 16'd1);

        // Level one short of a burst: must stay idle.
        fill_random();
        expect_packet();
        for (int i = 0; i < BL - 1; i++) fifo_q.push_back(pkt_w[i]);
        update_flags();
        for (int k = 0; k < 4; k++) begin
            tick();
            check("short_busy", busy, 1'b0);
            check("short_fifo_rd", fifo_rd, 1'b0);
        end
        fifo_q.push_back(pkt_w[BL-1]);
        update_flags();
        tick();
        check("start_busy", busy, 1'b1);
        check("start_valid", out_valid, 1'b1);
        check("start_header", out_data, 16'd1);
        run_until_drained(100);
        check("level_pkt_count", pkt_count, 16'd2);

        // Back-to-back packets: one idle cycle between them.
        fill_random();
        load_packet();
        fill_random();
        load_packet();
        run_until_drained(100);
        check("b2b_idle_gap", last_gap, 1);
        check("b2b_pkt_count", pkt_count, 16'd4);

        // Under-run mid-payload plus enable dropped mid-packet.
        fill_random();
        load_packet();
        wait_beats(2);
        enable      = 1'b0;
        force_empty = 1'b1;
        update_flags();
        rd0 = n_rd;
        repeat (5) tick();
        check("stall_no_rd", n_rd - rd0, 0);
        check("stall_valid", out_valid, 1'b0);
        check("stall_busy", busy, 1'b1);
        force_empty = 1'b0;
        update_flags();
        run_until_drained(100);
        check("stall_pkt_count", pkt_count, 16'd5);

        // enable low: a full burst waits.
        fill_random();
        load_packet();
        rd0 = n_rd;
        repeat (10) tick();
        check("disabled_busy", busy, 1'b0);
        check("disabled_no_rd", n_rd - rd0, 0);
        check("disabled_pending", exp_q.size(), BL + 2);
        enable = 1'b1;
        run_until_drained(100);
        check("enable_pkt_count", pkt_count, 16'd6);

        // Random back-pressure and FIFO empty glitches, random data.
        rand_ready   = 1'b1;
        glitch_empty = 1'b1;
        for (int p = 0; p < 8; p++) begin
            fill_random();
            load_packet();
        end
        run_until_drained(3000);
        glitch_empty = 1'b0;
        force_empty  = 1'b0;
        rand_ready   = 1'b0;
        update_flags();
        check("random_pkt_count", pkt_count, 16'd14);

        // Reset during payload word 2; the partial packet is lost.
        fill_random();
        load_packet();
        wait_beats(2);
        rst = 1'b0;
        tick();
        fifo_q.delete();
        exp_q.delete();
        model_seq = 0;
        update_flags();
        check_reset("mid");
        rst = 1'b1;

        // Ten packets of 0xFFFF under random back-pressure, headers 0..9.
        rand_ready = 1'b1;
        for (int p = 0; p < 10; p++) begin
            fill_const(16'hFFFF);
            load_packet();
        end
        run_until_drained(3000);
        rand_ready = 1'b0;
        check("ffff_pkt_count", pkt_count, 16'd10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
